// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file.
// Holds the clear-FSM encoding, default widths and the zero register index.
package regfile_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam int REG_DATA_W   = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int ZERO_REG_IDX = 0;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: walks every row once after a clear request.
// Ports: clk, reset (async, high), clear_req in; busy, clr_start, clr_row_en, clr_row_addr out.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_start,
  output logic              clr_row_en,
  output logic [ADDR_W-1:0] clr_row_addr
);

  localparam logic [ADDR_W-1:0] LAST_ROW = '1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        // Counter wraps back to 0 on the exit edge.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ROW) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy         = (state_q == ST_CLEAR);
  assign clr_start    = (state_q == ST_IDLE) && clear_req;
  assign clr_row_en   = busy;
  assign clr_row_addr = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// N-read/1-write register file with per-register pending bits and bulk clear.
// Ports: clk, reset, regWrite/writeReg/writeData, issueValid/issueReg, clearReq,
// readReg in; readData, readBusy, busy out. Macro REGFILE_BYPASS_EN adds write-through reads.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     regWrite,
  input  logic [ADDR_W-1:0]        writeReg,
  input  logic [DATA_W-1:0]        writeData,
  input  logic                     issueValid,
  input  logic [ADDR_W-1:0]        issueReg,
  input  logic                     clearReq,
  input  logic [NUM_RD*ADDR_W-1:0] readReg,
  output logic [NUM_RD*DATA_W-1:0] readData,
  output logic [NUM_RD-1:0]        readBusy,
  output logic                     busy
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;

  logic              clr_start;
  logic              clr_row_en;
  logic [ADDR_W-1:0] clr_row_addr;
  logic              wr_acc;
  logic              iss_acc;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == ADDR_W'(ZERO_REG_IDX));
  endfunction

  regfile_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk          (clk),
    .reset        (reset),
    .clear_req    (clearReq),
    .busy         (busy),
    .clr_start    (clr_start),
    .clr_row_en   (clr_row_en),
    .clr_row_addr (clr_row_addr)
  );

  // A clear starting this edge also drops the write and issue.
  assign wr_acc  = regWrite && !busy && !clr_start
                && !is_zero(writeReg);
  assign iss_acc = issueValid && !busy && !clr_start
                && !is_zero(issueReg);

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (clr_row_en) begin
      regs_d[clr_row_addr] = '0;
    end
    if (wr_acc) begin
      regs_d[writeReg] = writeData;
    end
    if (clr_start) begin
      pend_d = '0;
    end
    if (wr_acc) begin
      pend_d[writeReg] = 1'b0;
    end
    // Issue after write: a new producer on the same edge keeps it pending.
    if (iss_acc) begin
      pend_d[issueReg] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_ok;
  assign byp_ok = wr_acc && !(iss_acc && (issueReg == writeReg));
`endif

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rb;

    assign ra = readReg[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd = regs_q[ra];
      rb = pend_q[ra];
`ifdef REGFILE_BYPASS_EN
      if (byp_ok && (ra == writeReg)) begin
        rd = writeData;
        rb = 1'b0;
      end
`endif
      if (is_zero(ra)) begin
        rd = '0;
        rb = 1'b0;
      end
    end

    assign readData[i*DATA_W +: DATA_W] = rd;
    assign readBusy[i]                  = rb;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed table, corner sequences,
// and random traffic against a behavioural model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        issueValid;
  logic [4:0]  issueReg;
  logic        clearReq;
  logic [9:0]  readReg;
  logic [63:0] readData;
  logic [1:0]  readBusy;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .regWrite   (regWrite),
    .writeReg   (writeReg),
    .writeData  (writeData),
    .issueValid (issueValid),
    .issueReg   (issueReg),
    .clearReq   (clearReq),
    .readReg    (readReg),
    .readData   (readData),
    .readBusy   (readBusy),
    .busy       (busy)
  );

  // Behavioural model: storage, pending flags, remaining clear cycles.
  logic [31:0] m_regs [32];
  logic        m_pend [32];
  int          m_left;

  typedef struct {
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic        eb0;
    logic [31:0] e1;
    logic        eb1;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_left = 0;
  endtask

  task automatic m_step();
    if (m_left > 0) begin
      m_regs[32 - m_left] = '0;
      m_left--;
    end else if (clearReq) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      m_left = 32;
    end else begin
      if (regWrite && writeReg != 0) begin
        m_regs[writeReg] = writeData;
        m_pend[writeReg] = 1'b0;
      end
      if (issueValid && issueReg != 0) m_pend[issueReg] = 1'b1;
    end
  endtask

  task automatic m_read(input logic [4:0] a, output logic [31:0] d,
                        output logic b);
    d = m_regs[a];
    b = m_pend[a];
`ifdef REGFILE_BYPASS_EN
    if (m_left == 0 && !clearReq && regWrite && writeReg != 0
        && a == writeReg && !(issueValid && issueReg == writeReg)) begin
      d = writeData;
      b = 1'b0;
    end
`endif
    if (a == 0) begin
      d = '0;
      b = 1'b0;
    end
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    regWrite   = 1'b0;
    writeReg   = '0;
    writeData  = '0;
    issueValid = 1'b0;
    issueReg   = '0;
    clearReq   = 1'b0;
  endtask

  task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
    readReg = {a1, a0};
    #2;
  endtask

  initial begin
    logic [31:0] ed;
    logic        eb;
    int          cnt;

    vecs[0] = '{1'b1, 5'd1, 32'hDEADBEEF, 1'b0, 5'd0, 5'd1, 5'd2,
                32'hDEADBEEF, 1'b0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd2, 5'd1,
                32'h0, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 5'd2, 32'hCAFEBABE, 1'b0, 5'd0, 5'd2, 5'd1,
                32'hCAFEBABE, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{1'b1, 5'd3, 32'h11111111, 1'b1, 5'd3, 5'd3, 5'd2,
                32'h11111111, 1'b1, 32'hCAFEBABE, 1'b0};
    vecs[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd3,
                32'h0, 1'b0, 32'h11111111, 1'b1};
    vecs[5] = '{1'b1, 5'd3, 32'h22222222, 1'b1, 5'd4, 5'd3, 5'd4,
                32'h22222222, 1'b0, 32'h0, 1'b1};

    idle_in();
    m_reset();
    reset   = 1'b1;
    readReg = {5'd2, 5'd1};
    #3;
    check("rst_data0", readData[31:0], 32'h0);
    check("rst_data1", readData[63:32], 32'h0);
    check("rst_rbusy", {30'h0, readBusy}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    #7;
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      regWrite   = vecs[v].wr;
      writeReg   = vecs[v].wa;
      writeData  = vecs[v].wd;
      issueValid = vecs[v].iss;
      issueReg   = vecs[v].ia;
      tick();
      idle_in();
      rd2(vecs[v].ra0, vecs[v].ra1);
      check($sformatf("vec%0d_d0", v), readData[31:0], vecs[v].e0);
      check($sformatf("vec%0d_b0", v), {31'h0, readBusy[0]},
            {31'h0, vecs[v].eb0});
      check($sformatf("vec%0d_d1", v), readData[63:32], vecs[v].e1);
      check($sformatf("vec%0d_b1", v), {31'h0, readBusy[1]},
            {31'h0, vecs[v].eb1});
    end

    // Fill, mark r9 pending, then bulk clear with writes hammering r5.
    for (int i = 1; i < 32; i++) begin
      regWrite  = 1'b1;
      writeReg  = 5'(i);
      writeData = 32'(i);
      tick();
    end
    idle_in();
    issueValid = 1'b1;
    issueReg   = 5'd9;
    tick();
    idle_in();
    rd2(5'd9, 5'd31);
    check("fill_pend9", {31'h0, readBusy[0]}, 32'h1);
    check("fill_r31", readData[63:32], 32'd31);
    clearReq  = 1'b1;
    regWrite  = 1'b1;
    writeReg  = 5'd5;
    writeData = 32'hBAD0BAD0;
    tick();
    clearReq = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      tick();
      cnt++;
    end
    check("clear_busy_cycles", 32'(cnt), 32'd32);
    idle_in();
    for (int i = 0; i < 32; i += 2) begin
      rd2(5'(i), 5'(i + 1));
      check($sformatf("clr_d%0d", i), readData[31:0], 32'h0);
      check($sformatf("clr_d%0d", i + 1), readData[63:32], 32'h0);
      check($sformatf("clr_b%0d", i), {30'h0, readBusy}, 32'h0);
    end

    // Reset in the middle of a clear.
    clearReq = 1'b1;
    tick();
    clearReq = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("midclr_busy", {31'h0, busy}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("midclr_rst_busy", {31'h0, busy}, 32'h0);
    #1;
    reset = 1'b0;
    m_reset();
    regWrite  = 1'b1;
    writeReg  = 5'd5;
    writeData = 32'h12345678;
    tick();
    idle_in();
    rd2(5'd5, 5'd31);
    check("postrst_r5", readData[31:0], 32'h12345678);
    check("postrst_r31", readData[63:32], 32'h0);

    // Same-cycle read of the register being written.
    regWrite  = 1'b1;
    writeReg  = 5'd7;
    writeData = 32'h00000077;
    tick();
    writeData = 32'hA5A5A5A5;
    rd2(5'd7, 5'd5);
`ifdef REGFILE_BYPASS_EN
    check("bypass_r7", readData[31:0], 32'hA5A5A5A5);
`else
    check("nobypass_r7", readData[31:0], 32'h00000077);
`endif
    tick();
    idle_in();
    rd2(5'd7, 5'd5);
    check("after_r7", readData[31:0], 32'hA5A5A5A5);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      regWrite   = 1'($urandom_range(0, 1));
      writeReg   = 5'($urandom_range(0, 31));
      writeData  = $urandom;
      issueValid = 1'($urandom_range(0, 1));
      issueReg   = ($urandom_range(0, 3) == 0) ? writeReg
                                               : 5'($urandom_range(0, 31));
      clearReq   = ($urandom_range(0, 59) == 0);
      readReg[4:0] = ($urandom_range(0, 2) == 0) ? writeReg
                                                 : 5'($urandom_range(0, 31));
      readReg[9:5] = 5'($urandom_range(0, 31));
      #2;
      m_read(readReg[4:0], ed, eb);
      check("rnd_d0", readData[31:0], ed);
      check("rnd_b0", {31'h0, readBusy[0]}, {31'h0, eb});
      m_read(readReg[9:5], ed, eb);
      check("rnd_d1", readData[63:32], ed);
      check("rnd_b1", {31'h0, readBusy[1]}, {31'h0, eb});
      check("rnd_busy", {31'h0, busy}, (m_left > 0) ? 32'h1 : 32'h0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the 2-read/1-write register file: N combinational read ports, one write port, and a per-register pending (scoreboard) bit for the pipelined CPU datapath.
- Adds a sequenced bulk-clear state machine and an optional hardwired zero register.
- Sits between decode (read and issue) and writeback (write and pending release).

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and issues

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-high
regWrite  in  1  write enable (writeback)
writeReg  in  ADDR_W  write address
writeData  in  DATA_W  write data
issueValid  in  1  mark destination pending
issueReg  in  ADDR_W  destination being issued
clearReq  in  1  start bulk clear (pulse)
readReg  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
readData  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
readBusy  out  NUM_RD  pending bit of each addressed register
busy  out  1  clear in progress; writes and issues dropped

Behaviour:
- Reset (asynchronous): all registers 0, all pending bits 0, state IDLE, clear counter 0, busy 0. readData and readBusy therefore read 0.
- Reads are combinational, with zero latency:
  - readData[i] = regs[readReg[i]].
  - readBusy[i] = pending[readReg[i]].
  - With ZERO_REG=1, an address of 0 gives readData 0 and readBusy 0.
- Write: accepted at the rising edge when regWrite=1, busy=0, and the address is not the zero register (ZERO_REG=1, writeReg=0 is ignored).
  - Sets regs[writeReg] <= writeData.
  - Clears pending[writeReg] <= 0.
- Issue: accepted at the rising edge when issueValid=1, busy=0, and the address is not the zero register. Sets pending[issueReg] <= 1.
- Same edge, issueReg == writeReg: data is written and pending ends at 1 (the new producer wins).
- Different addresses on the same edge: both actions take effect.
- FSM states are IDLE and CLEAR.
  - IDLE -> CLEAR on clearReq=1: counter <= 0 and all pending bits <= 0 on that edge.
  - CLEAR: each edge writes regs[counter] <= 0 and increments counter. After the edge that writes DEPTH-1, state returns to IDLE.
  - busy = (state == CLEAR), so busy stays high for exactly DEPTH cycles.
  - clearReq during CLEAR is ignored.
  - clearReq together with regWrite in IDLE: the clear wins and the write is dropped.
  - Reads during CLEAR return current contents, partially cleared.
- Reset during CLEAR: the FSM returns to IDLE immediately and all state is zeroed.
- No overflow cases: the counter is ADDR_W bits wide and wraps only on exit.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read port whose address equals an accepted write address in the same cycle (regWrite=1, busy=0, non-zero register) returns writeData and readBusy=0. This is a combinational write-through bypass, unless an issue to the same register is also accepted that cycle.
- Undefined: the read returns the old stored value and the old pending bit until after the edge.

Decomposition:
- Shared package regfile_pkg holds:
  - the FSM state encoding (ST_IDLE=1'b0, ST_CLEAR=1'b1);
  - default-width constants (REG_DATA_W=32, REG_ADDR_W=5);
  - the ZERO_REG_IDX constant.
- Sub-module regfile_clear_fsm (state, counter, busy, clear-row strobe and address). The storage and ports stay in the top module.

Test Plan:
- Assert reset for 10 ns -> readData=0, readBusy=0, busy=0 on all ports. Write 32'hDEADBEEF to r1 -> next cycle, readReg port0=1 gives 32'hDEADBEEF.
- Issue r2 -> readBusy for r2 =1. Write 32'hCAFEBABE to r2 -> readBusy=0 and readData=32'hCAFEBABE. Issue and write r3 on the same edge -> data is written and readBusy=1.
- ZERO_REG=1: write 32'hFFFFFFFF to r0 and issue r0 -> readData=0 and readBusy=0.
- Fill r1..r31 with value i, then pulse clearReq -> busy high for exactly 32 cycles. Writes during the clear are dropped. Afterwards all reads are 0 and all pending bits are 0.
- Assert reset at clear cycle 10 -> busy=0 immediately, and a write of 32'h12345678 to r5 on the next edge is accepted.
- REGFILE_BYPASS_EN: write 32'hA5A5A5A5 to r7 while reading r7 -> readData=32'hA5A5A5A5 in the same cycle. Without the macro -> the old value is returned.
